// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and frame constants.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

  localparam int   FRAME_BITS = 11;
  localparam int   DATA_BITS  = 8;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Keyboard lines in, scan-code strobe/error out.
interface ps2_kbd_rx_if;
  import ps2_pkg::*;

  logic                 ps2_clk_i;
  logic                 ps2_data_i;
  logic [DATA_BITS-1:0] code_o;
  logic                 strobe_o;
  logic                 err_o;

  // master drives the PS/2 lines (keyboard side), slave is the receiver
  modport master (output ps2_clk_i, ps2_data_i, input code_o, strobe_o, err_o);
  modport slave  (input ps2_clk_i, ps2_data_i, output code_o, strobe_o, err_o);
endinterface

// File: rtl/ps2_rx_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one PS/2 line.
module ps2_rx_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic          filt;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive synced samples disagree with the filtered level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            filt <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout = filt;
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver. Optional inactivity timeout: define PS2_KBD_RX_TIMEOUT_EN.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FREQ_HZ    = 1_000_000,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_US = 2000
) (
    input  logic           clk,
    input  logic           reset_i,
    ps2_kbd_rx_if.slave    bus
);
    localparam int CNT_W          = $clog2(FRAME_BITS);
    localparam int TIMEOUT_CYCLES = FREQ_HZ / 1_000_000 * TIMEOUT_US;

    if (FREQ_HZ % 1_000_000 != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("ps2_kbd_rx: FREQ_HZ must be a whole MHz and the timeout at least 2 cycles");
    end

    logic clk_f, data_f, clk_f_q, fall;

    ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
        .clk(clk), .rst(reset_i), .din(bus.ps2_clk_i), .dout(clk_f));
    ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_data_flt (
        .clk(clk), .rst(reset_i), .din(bus.ps2_data_i), .dout(data_f));

    ps2_rx_state_t        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, code_q, code_d;
    logic                 par_q, par_d, strobe_q, strobe_d, err_q, err_d;

`ifdef PS2_KBD_RX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    assign fall = clk_f_q & ~clk_f;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            clk_f_q  <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            code_q   <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_KBD_RX_TIMEOUT_EN
            tmr_q    <= '0;
`endif
        end else begin
            clk_f_q  <= clk_f;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
`ifdef PS2_KBD_RX_TIMEOUT_EN
            tmr_q    <= tmr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        code_d   = code_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (data_f == START_LVL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d = {data_f, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_f;
                    state_d = STOP;
                end
                STOP: begin
                    // odd parity over data plus parity bit
                    if (data_f == STOP_LVL && ^{shreg_q, par_q}) begin
                        code_d   = shreg_q;
                        strobe_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef PS2_KBD_RX_TIMEOUT_EN
        // a lost edge leaves the frame stuck; drop it so the next start bit resyncs
        else if (state_q != IDLE && tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end
        tmr_d = (fall || state_q == IDLE) ? '0 : tmr_q + 1'b1;
`endif
    end

    assign bus.code_o   = code_q;
    assign bus.strobe_o = strobe_q;
    assign bus.err_o    = err_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: 1 MHz clock, 50 us PS/2 bit period.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   total = 0, bad = 0;
    int   n_strb = 0, n_err = 0, n_both = 0;
    int   e_strb = 0, e_err = 0;
    logic [7:0] codes[$];

    ps2_kbd_rx_if kb();

    ps2_kbd_rx #(.FREQ_HZ(1_000_000), .FILTER_LEN(4), .TIMEOUT_US(2000)) dut (
        .clk(clk), .reset_i(reset_i), .bus(kb));

    always #500 clk = ~clk;

    always @(negedge clk) begin
        if (!reset_i) begin
            if (kb.strobe_o) begin n_strb++; codes.push_back(kb.code_o); end
            if (kb.err_o) n_err++;
            if (kb.strobe_o && kb.err_o) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                             input logic stop);
        logic par;
        par = ~^code ^ bad_par;
        return {stop, par, code, 1'b0};
    endfunction

    // bits lo..hi of frame f; optional 1-cycle clock glitch in the high phase of bit gl
    task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input int gl);
        for (int i = lo; i <= hi; i++) begin
            kb.ps2_data_i = f[i];
            repeat (12) @(negedge clk);
            kb.ps2_clk_i = 1'b0;
            repeat (25) @(negedge clk);
            kb.ps2_clk_i = 1'b1;
            if (i == gl) begin
                repeat (5) @(negedge clk);
                kb.ps2_clk_i = 1'b0;
                @(negedge clk);
                kb.ps2_clk_i = 1'b1;
                repeat (7) @(negedge clk);
            end else begin
                repeat (13) @(negedge clk);
            end
        end
        kb.ps2_data_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] code, input logic bad_par, input logic stop);
        send_bits(mk_frame(code, bad_par, stop), 0, 10, -1);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_strb"}, n_strb, e_strb);
        chk({tag, "_err"},  n_err,  e_err);
    endtask

    initial begin
        kb.ps2_clk_i  = 1'b1;
        kb.ps2_data_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_code", kb.code_o, 8'h00);
        chk("rst_strb", kb.strobe_o, 1'b0);
        chk("rst_err",  kb.err_o, 1'b0);
        reset_i = 1'b0;
        repeat (20) @(negedge clk);
        chk_counts("idle");

        send(8'h1C, 1'b0, 1'b1); e_strb++;
        chk_counts("v1c");
        chk("v1c_code", kb.code_o, 8'h1C);

        send(8'hF0, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b1); e_strb += 2;
        chk_counts("b2b");
        chk("b2b_first",  codes[1], 8'hF0);
        chk("b2b_second", codes[2], 8'h1C);

        send(8'hF0, 1'b0, 1'b1); e_strb++;
        send(8'h1C, 1'b1, 1'b1); e_err++;
        chk_counts("par");
        chk("par_code", kb.code_o, 8'hF0);

        send(8'h29, 1'b0, 1'b0); e_err++;
        chk_counts("stop0");
        chk("stop0_code", kb.code_o, 8'hF0);
        send(8'h29, 1'b0, 1'b1); e_strb++;
        chk_counts("v29");
        chk("v29_code", kb.code_o, 8'h29);

        // a lone falling edge with data high is not a start bit
        send_bits(11'h7FF, 0, 0, -1); e_err++;
        chk_counts("nostart");

        send_bits(mk_frame(8'h77, 1'b0, 1'b1), 0, 10, 4); e_strb++;
        chk_counts("glitch");
        chk("glitch_code", kb.code_o, 8'h77);

        send_bits(mk_frame(8'h33, 1'b0, 1'b1), 0, 5, -1);
        reset_i = 1'b1;
        #1;
        chk("mrst_code", kb.code_o, 8'h00);
        chk("mrst_strb", kb.strobe_o, 1'b0);
        chk("mrst_err",  kb.err_o, 1'b0);
        repeat (5) @(negedge clk);
        reset_i = 1'b0;
        repeat (100) @(negedge clk);
        chk_counts("mrst");
        chk("mrst_hold", kb.code_o, 8'h00);
        send(8'h12, 1'b0, 1'b1); e_strb++;
        chk_counts("after_rst");
        chk("after_rst_code", kb.code_o, 8'h12);

        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 0, 4, -1);
        repeat (3000) @(negedge clk);
`ifdef PS2_KBD_RX_TIMEOUT_EN
        e_err++;
        chk_counts("tmo");
        send(8'h5A, 1'b0, 1'b1); e_strb++;
`else
        chk_counts("no_tmo");
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5, 10, -1); e_strb++;
`endif
        chk_counts("tmo_after");
        chk("tmo_code", kb.code_o, 8'h5A);
        chk("both_high", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
